// File: rtl/nist_test_sequencer.sv
// Run-control for a bank of on-chip randomness test engines: streams entropy bits
// in fixed windows, samples the engines' pass flags and issues per-engine verdicts.
module nist_test_sequencer #(
  parameter int NUM_ENG     = 4,
  parameter int WINDOW      = 1032000,
  parameter int SETTLE      = 2,
  parameter int RST_CYC     = 2,
  parameter int RUNS        = 8,
  parameter int PASS_MIN    = 7,
  parameter int MAX_RESTART = 3,
  parameter int CNT_W       = 21,
  parameter int RUN_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     rand_in,
  input  logic                     rand_valid,
  output logic                     eng_rst,
  output logic                     eng_rand,
  input  logic [NUM_ENG-1:0]       eng_pass,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [NUM_ENG-1:0]       verdict,
  output logic [NUM_ENG*RUN_W-1:0] pass_cnt,
  output logic [7:0]               gap_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ERST   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [RUN_W-1:0] RUNS_V     = RUN_W'(RUNS);
  localparam logic [RUN_W-1:0] PASS_MIN_V = RUN_W'(PASS_MIN);
  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);

  // Restart counter only has to reach MAX_RESTART+1, the value that aborts the campaign.
  localparam int               RS_W   = $clog2(MAX_RESTART + 2);
  localparam logic [RS_W-1:0]  RS_MAX = RS_W'(MAX_RESTART);
  localparam logic [RS_W-1:0]  RS_ONE = RS_W'(1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [RUN_W-1:0]  run;
  logic [RS_W-1:0]   restart;
  logic [RUN_W-1:0]  pass_r  [NUM_ENG];
  logic [RUN_W-1:0]  pass_nx [NUM_ENG];
  logic [NUM_ENG-1:0] verdict_nx;
  logic [RUN_W-1:0]  run_inc;
  logic [RS_W-1:0]   restart_inc;

  assign run_inc     = run + RUN_ONE;
  assign restart_inc = restart + RS_ONE;

  assign eng_rst  = (state == S_IDLE) || (state == S_ERST);
  assign eng_rand = (state == S_STREAM) ? rand_in : 1'b0;
  assign busy     = (state != S_IDLE);

  // Verdict is taken from the counts as they will stand after the final sample.
  always_comb begin
    for (int i = 0; i < NUM_ENG; i++) begin
      pass_nx[i]    = pass_r[i] + RUN_W'(eng_pass[i]);
      verdict_nx[i] = (pass_nx[i] >= PASS_MIN_V);
    end
  end

  for (genvar g = 0; g < NUM_ENG; g++) begin : g_pack
    assign pass_cnt[g*RUN_W +: RUN_W] = pass_r[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      run     <= '0;
      restart <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      verdict <= '0;
      gap_cnt <= '0;
      for (int i = 0; i < NUM_ENG; i++) pass_r[i] <= '0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && abort) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state   <= S_ERST;
              cnt     <= '0;
              run     <= '0;
              restart <= '0;
              err     <= 1'b0;
              verdict <= '0;
              gap_cnt <= '0;
              for (int i = 0; i < NUM_ENG; i++) pass_r[i] <= '0;
            end
          end
          S_ERST: begin
            if (cnt == RST_LAST) begin
              cnt   <= '0;
              state <= S_STREAM;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_STREAM: begin
            // A missing bit corrupts the engines' window, so the window is thrown away.
            if (!rand_valid) begin
              if (gap_cnt != 8'hFF) gap_cnt <= gap_cnt + 8'd1;
              restart <= restart_inc;
              cnt     <= '0;
              if (restart_inc > RS_MAX) begin
                done  <= 1'b1;
                err   <= 1'b1;
                state <= S_IDLE;
              end else begin
                state <= S_ERST;
              end
            end else if (cnt == WIN_LAST) begin
              cnt   <= '0;
              state <= S_SETTLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_SETTLE: begin
            if (cnt == SET_LAST) begin
              cnt   <= '0;
              state <= S_SAMPLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_SAMPLE: begin
            for (int i = 0; i < NUM_ENG; i++) pass_r[i] <= pass_nx[i];
            run <= run_inc;
            if (run_inc == RUNS_V) begin
              verdict <= verdict_nx;
              done    <= 1'b1;
              state   <= S_IDLE;
            end else begin
              state <= S_ERST;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nist_test_sequencer.sv
// Directed bench for nist_test_sequencer: table-driven full campaigns plus
// hand-written gap, error and abort sequences with hand-computed timing.
module tb_nist_test_sequencer;

  localparam int NUM_ENG = 2;
  localparam int RUN_W   = 4;
  localparam int RUN_LEN = 21;

  logic clk = 1'b0;
  logic rst, start, abort, rand_in, rand_valid;
  logic eng_rst, eng_rand, busy, done, err;
  logic [NUM_ENG-1:0]       eng_pass;
  logic [NUM_ENG-1:0]       verdict;
  logic [NUM_ENG*RUN_W-1:0] pass_cnt;
  logic [7:0]               gap_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] pats;
    int         pc0;
    int         pc1;
    int         verd;
  } vec_t;

  vec_t vecs [5];

  nist_test_sequencer #(
    .NUM_ENG(NUM_ENG), .WINDOW(16), .SETTLE(2), .RST_CYC(2), .RUNS(3),
    .PASS_MIN(2), .MAX_RESTART(1), .CNT_W(21), .RUN_W(RUN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rand_in(rand_in), .rand_valid(rand_valid),
    .eng_rst(eng_rst), .eng_rand(eng_rand), .eng_pass(eng_pass),
    .busy(busy), .done(done), .err(err), .verdict(verdict),
    .pass_cnt(pass_cnt), .gap_cnt(gap_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic apply_stimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs until done, switching eng_pass per run; returns cycles after the start edge or -1.
  task automatic run_until_done(input logic [5:0] pats, output int lat);
    int r;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      r = k / RUN_LEN;
      if (r > 2) r = 2;
      eng_pass   = pats[2*r +: 2];
      rand_valid = 1'b1;
      tick();
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{pats: 6'b11_11_11, pc0: 3, pc1: 3, verd: 3};
    vecs[1] = '{pats: 6'b00_01_01, pc0: 2, pc1: 0, verd: 1};
    vecs[2] = '{pats: 6'b10_00_10, pc0: 0, pc1: 2, verd: 2};
    vecs[3] = '{pats: 6'b01_11_00, pc0: 2, pc1: 1, verd: 1};
    vecs[4] = '{pats: 6'b00_00_00, pc0: 0, pc1: 0, verd: 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; rand_in = 1'b1; rand_valid = 1'b1; eng_pass = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_output("reset_eng_rst", eng_rst, 1);
    check_output("reset_eng_rand", eng_rand, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_err", err, 0);
    check_output("reset_verdict", verdict, 0);
    check_output("reset_pass_cnt", pass_cnt, 0);
    check_output("reset_gap_cnt", gap_cnt, 0);

    for (int v = 0; v < 5; v++) begin
      apply_stimulus();
      check_output($sformatf("v%0d_busy", v), busy, 1);
      run_until_done(vecs[v].pats, lat);
      check_output($sformatf("v%0d_latency", v), lat, 63);
      check_output($sformatf("v%0d_pass0", v), pass_cnt[3:0], vecs[v].pc0);
      check_output($sformatf("v%0d_pass1", v), pass_cnt[7:4], vecs[v].pc1);
      check_output($sformatf("v%0d_verdict", v), verdict, vecs[v].verd);
      check_output($sformatf("v%0d_err", v), err, 0);
      check_output($sformatf("v%0d_idle", v), busy, 0);
      tick();
      check_output($sformatf("v%0d_done_pulse", v), done, 0);
    end

    // Single gap at stream bit 10 of run 1: window restarts, campaign still succeeds.
    apply_stimulus();
    eng_pass = 2'b11;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      rand_valid = (k != 12);
      rand_in    = (k != 6);
      #1;
      if (k == 0)  check_output("gap_erst_rand", eng_rand, 0);
      if (k == 1)  check_output("gap_erst2_rst", eng_rst, 1);
      if (k == 2)  check_output("gap_stream_rst", eng_rst, 0);
      if (k == 5)  check_output("gap_rand_hi", eng_rand, 1);
      if (k == 6)  check_output("gap_rand_lo", eng_rand, 0);
      if (k == 13) check_output("gap_rerst1", eng_rst, 1);
      if (k == 13) check_output("gap_cnt_one", gap_cnt, 1);
      if (k == 14) check_output("gap_rerst2", eng_rst, 1);
      if (k == 15) check_output("gap_restream", eng_rst, 0);
      tick();
    end
    rand_in = 1'b1;
    rand_valid = 1'b1;
    check_output("gap_latency", lat, 76);
    check_output("gap_err", err, 0);
    check_output("gap_total", gap_cnt, 1);
    check_output("gap_pass0", pass_cnt[3:0], 3);
    check_output("gap_verdict", verdict, 3);

    // Two gaps exceed the restart limit.
    apply_stimulus();
    for (int k = 0; k < 11; k++) begin
      rand_valid = !(k == 5 || k == 10);
      tick();
    end
    rand_valid = 1'b1;
    check_output("gap2_done", done, 1);
    check_output("gap2_err", err, 1);
    check_output("gap2_busy", busy, 0);
    check_output("gap2_gap_cnt", gap_cnt, 2);
    check_output("gap2_verdict", verdict, 0);
    tick();
    check_output("gap2_done_pulse", done, 0);
    check_output("gap2_err_held", err, 1);

    // Abort during SETTLE of run 2.
    apply_stimulus();
    check_output("restart_err_clear", err, 0);
    for (int k = 0; k < 40; k++) begin
      eng_pass = (k < RUN_LEN) ? 2'b01 : 2'b11;
      abort    = (k == 39);
      tick();
    end
    abort = 1'b0;
    check_output("abort_busy", busy, 0);
    check_output("abort_done", done, 0);
    check_output("abort_pass0", pass_cnt[3:0], 1);
    check_output("abort_pass1", pass_cnt[7:4], 0);
    check_output("abort_verdict", verdict, 0);
    check_output("abort_eng_rst", eng_rst, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("abort_no_done", done, 0);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_output("start_abort_idle", busy, 0);
    apply_stimulus();
    check_output("new_start_busy", busy, 1);
    check_output("new_start_clear", pass_cnt, 0);

    // Synchronous reset mid-campaign.
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("rst_mid_busy", busy, 0);
    check_output("rst_mid_eng_rst", eng_rst, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
